// File: rtl/s32x_vdp_bus_master_pkg.sv
// Shared types and constants for the 32X VDP bus master.
// Holds bus space codes, FSM state encoding and the timeout counter width.
package s32x_vdp_bus_master_pkg;

  typedef enum logic [1:0] {
    SP_REG  = 2'd0,
    SP_DRAM = 2'd1,
    SP_PAL  = 2'd2
  } VDPM_SPACE_t;

  typedef enum logic [1:0] {
    VM_IDLE,
    VM_SETUP,
    VM_STRB,
    VM_RLS
  } VDPM_STATE_t;

  localparam int unsigned VDPM_TMO_W = 10;

  // Requests completed locally with an error and no bus cycle: the reserved space,
  // and palette writes that are not full-word (the palette is word-write only).
  function automatic logic vdpm_no_bus_cycle(input logic [1:0] space, input logic we,
                                             input logic [1:0] be);
    return (space == 2'b11) || ((space == SP_PAL) && we && (be != 2'b11));
  endfunction

endpackage

// File: rtl/s32x_vdp_bus_master.sv
// Initiator for the 32X VDP register/framebuffer/palette bus: REQ pulse -> CS/strobe/ACK_N cycle.
// Optional ACK_N timeout is built in when the macro S32X_VDPM_TIMEOUT_EN is defined.
module s32x_vdp_bus_master
  import s32x_vdp_bus_master_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned TMO_CYC   = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic [1:0]  REQ_SPACE,
  input  logic [16:0] REQ_A,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_BE,
  input  logic [15:0] REQ_WD,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [15:0] RD_DATA,
  output logic [16:0] A,
  output logic [15:0] DO,
  input  logic [15:0] DI,
  output logic        RD_N,
  output logic        LWR_N,
  output logic        UWR_N,
  output logic        REG_CS_N,
  output logic        DRAM_CS_N,
  output logic        PAL_CS_N,
  input  logic        ACK_N
);

  if (SETUP_CYC < 1 || SETUP_CYC > 3) begin : g_bad_setup_cyc
    $error("SETUP_CYC must be in 1..3");
  end
  if (TMO_CYC >= (1 << VDPM_TMO_W)) begin : g_bad_tmo_cyc
    $error("TMO_CYC does not fit the timeout counter");
  end

  localparam logic [1:0] SetupLast = 2'(SETUP_CYC - 1);

  VDPM_STATE_t state_q, state_d;
  logic [1:0]  setup_cnt_q, setup_cnt_d;
  logic        we_q;
  logic [1:0]  be_q;

  logic        a_req_ok, accept, reject, setup_done;
  logic        tmo_hit, tmo_err_q;

  logic [16:0] a_d;
  logic [15:0] do_d, rd_data_d;
  logic        rd_n_d, lwr_n_d, uwr_n_d;
  logic        reg_cs_n_d, dram_cs_n_d, pal_cs_n_d;
  logic        busy_d, done_d, err_d;

  // A request is only taken while the responder has released ACK_N.
  assign a_req_ok   = REQ && ACK_N && (state_q == VM_IDLE);
  assign reject     = a_req_ok && vdpm_no_bus_cycle(REQ_SPACE, REQ_WE, REQ_BE);
  assign accept     = a_req_ok && !vdpm_no_bus_cycle(REQ_SPACE, REQ_WE, REQ_BE);
  assign setup_done = (setup_cnt_q == SetupLast);

`ifdef S32X_VDPM_TIMEOUT_EN
  logic [VDPM_TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q == VM_STRB) && (tmo_cnt_q == VDPM_TMO_W'(TMO_CYC));

  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q == VM_STRB && ACK_N) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
      if (accept) begin
        tmo_err_q <= 1'b0;
      end else if (tmo_hit && ACK_N) begin
        tmo_err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign tmo_err_q = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= VM_IDLE;
      setup_cnt_q <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      A           <= '0;
      DO          <= '0;
      RD_N        <= 1'b1;
      LWR_N       <= 1'b1;
      UWR_N       <= 1'b1;
      REG_CS_N    <= 1'b1;
      DRAM_CS_N   <= 1'b1;
      PAL_CS_N    <= 1'b1;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      RD_DATA     <= '0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      if (accept) begin
        we_q <= REQ_WE;
        be_q <= REQ_BE;
      end
      A           <= a_d;
      DO          <= do_d;
      RD_N        <= rd_n_d;
      LWR_N       <= lwr_n_d;
      UWR_N       <= uwr_n_d;
      REG_CS_N    <= reg_cs_n_d;
      DRAM_CS_N   <= dram_cs_n_d;
      PAL_CS_N    <= pal_cs_n_d;
      BUSY        <= busy_d;
      DONE        <= done_d;
      ERR         <= err_d;
      RD_DATA     <= rd_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = '0;
    unique case (state_q)
      VM_IDLE:  if (accept) state_d = VM_SETUP;
      VM_SETUP: begin
        if (setup_done) begin
          state_d = VM_STRB;
        end else begin
          setup_cnt_d = setup_cnt_q + 2'd1;
        end
      end
      VM_STRB:  if (!ACK_N || tmo_hit) state_d = VM_RLS;
      VM_RLS:   if (ACK_N) state_d = VM_IDLE;
      default:  state_d = VM_IDLE;
    endcase
  end

  always_comb begin
    a_d         = A;
    do_d        = DO;
    rd_n_d      = RD_N;
    lwr_n_d     = LWR_N;
    uwr_n_d     = UWR_N;
    reg_cs_n_d  = REG_CS_N;
    dram_cs_n_d = DRAM_CS_N;
    pal_cs_n_d  = PAL_CS_N;
    busy_d      = BUSY;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_data_d   = RD_DATA;
    unique case (state_q)
      VM_IDLE: begin
        if (reject) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else if (accept) begin
          a_d         = REQ_A;
          do_d        = REQ_WD;
          busy_d      = 1'b1;
          reg_cs_n_d  = (REQ_SPACE != SP_REG);
          dram_cs_n_d = (REQ_SPACE != SP_DRAM);
          pal_cs_n_d  = (REQ_SPACE != SP_PAL);
        end
      end
      VM_SETUP: begin
        if (setup_done) begin
          rd_n_d  = we_q;
          lwr_n_d = ~(we_q & be_q[0]);
          uwr_n_d = ~(we_q & be_q[1]);
        end
      end
      VM_STRB: begin
        // Strobes and CS stay put until the responder acks (or the timeout fires).
        if (!ACK_N || tmo_hit) begin
          rd_n_d      = 1'b1;
          lwr_n_d     = 1'b1;
          uwr_n_d     = 1'b1;
          reg_cs_n_d  = 1'b1;
          dram_cs_n_d = 1'b1;
          pal_cs_n_d  = 1'b1;
          if (!ACK_N) begin
            rd_data_d = we_q ? RD_DATA : DI;
          end else begin
            rd_data_d = 16'hFFFF;
          end
        end
      end
      VM_RLS: begin
        if (ACK_N) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          err_d  = tmo_err_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_s32x_vdp_bus_master.sv
// Bench for s32x_vdp_bus_master: behavioural VDP responder stub plus a memory/latency model.
// Build with S32X_VDPM_TIMEOUT_EN to exercise the ACK_N timeout instead of the endless wait.
module tb_s32x_vdp_bus_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic [1:0]  REQ_SPACE = '0;
  logic [16:0] REQ_A = '0;
  logic        REQ_WE = 1'b0;
  logic [1:0]  REQ_BE = '0;
  logic [15:0] REQ_WD = '0;
  logic        BUSY, DONE, ERR;
  logic [15:0] RD_DATA, DO, DI;
  logic [16:0] A;
  logic        RD_N, LWR_N, UWR_N, REG_CS_N, DRAM_CS_N, PAL_CS_N;
  logic        ACK_N = 1'b1;

  s32x_vdp_bus_master dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .REQ_SPACE (REQ_SPACE),
    .REQ_A     (REQ_A),
    .REQ_WE    (REQ_WE),
    .REQ_BE    (REQ_BE),
    .REQ_WD    (REQ_WD),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
    .RD_DATA   (RD_DATA),
    .A         (A),
    .DO        (DO),
    .DI        (DI),
    .RD_N      (RD_N),
    .LWR_N     (LWR_N),
    .UWR_N     (UWR_N),
    .REG_CS_N  (REG_CS_N),
    .DRAM_CS_N (DRAM_CS_N),
    .PAL_CS_N  (PAL_CS_N),
    .ACK_N     (ACK_N)
  );

  always #5 CLK = ~CLK;

  // Responder stub: acks stub_wait cycles after it sees a strobe (palette one more).
  int unsigned stub_wait  = 0;
  bit          stub_never = 1'b0;
  int unsigned wcnt       = 0;
  bit [15:0]   smem [0:524287];
  logic        strb_low;
  logic [1:0]  sel;

  always_comb begin
    strb_low = !RD_N || !LWR_N || !UWR_N;
    sel      = !REG_CS_N ? 2'd0 : (!DRAM_CS_N ? 2'd1 : 2'd2);
  end
  assign DI = smem[{sel, A}];

  always @(posedge CLK) begin
    if (strb_low && ACK_N) begin
      if (!stub_never && wcnt >= stub_wait + ((sel == 2'd2) ? 1 : 0)) begin
        ACK_N <= 1'b0;
        wcnt  <= 0;
        if (!LWR_N) smem[{sel, A}][7:0] <= DO[7:0];
        if (!UWR_N) smem[{sel, A}][15:8] <= DO[15:8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else if (!strb_low) begin
      ACK_N <= 1'b1;
      wcnt  <= 0;
    end
  end

  // Monitor: strobe-low cycle count, last strobe/CS pattern, strobe releases without an ack.
  int         strb_cyc  = 0;
  int         glitches  = 0;
  logic [5:0] strb_pat  = 6'h3f;
  logic       prev_hold = 1'b0;

  always @(posedge CLK) begin
    if (strb_low) begin
      strb_cyc <= strb_cyc + 1;
      strb_pat <= {REG_CS_N, DRAM_CS_N, PAL_CS_N, RD_N, UWR_N, LWR_N};
    end
    if (prev_hold && !strb_low) glitches <= glitches + 1;
    prev_hold <= strb_low && ACK_N && !RST;
  end

  int errors = 0;
  int checks = 0;
  bit [15:0] mdl [0:524287];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic [1:0] sp, input logic [16:0] a, input logic we,
                        input logic [1:0] be, input logic [15:0] wd,
                        output int lat, output int scyc);
    int s0;
    @(negedge CLK);
    REQ = 1'b1; REQ_SPACE = sp; REQ_A = a; REQ_WE = we; REQ_BE = be; REQ_WD = wd;
    s0 = strb_cyc;
    @(posedge CLK); #1;
    REQ = 1'b0;
    lat = 0;
    while (DONE !== 1'b1 && lat < 3000) begin
      @(posedge CLK); #1;
      lat++;
    end
    scyc = strb_cyc - s0;
  endtask

  // One access checked against the model: latency, ERR, read data, strobe-low cycles.
  task automatic run(input logic [1:0] sp, input logic [16:0] a, input logic we,
                     input logic [1:0] be, input logic [15:0] wd, input int unsigned w,
                     input string tag);
    int lat, scyc, pal;
    bit nobus;
    logic [18:0] key;
    nobus = (sp == 2'd3) || (sp == 2'd2 && we && be != 2'b11);
    pal   = (sp == 2'd2) ? 1 : 0;
    key   = {sp, a};
    stub_wait = w;
    access(sp, a, we, be, wd, lat, scyc);
    chk({tag, "_lat"}, lat, nobus ? 0 : 5 + w + pal);
    chk({tag, "_err"}, {31'd0, ERR}, {31'd0, nobus});
    chk({tag, "_strb"}, scyc, nobus ? 0 : 2 + w + pal);
    if (!nobus && !we) chk({tag, "_rd"}, {16'd0, RD_DATA}, {16'd0, mdl[key]});
    if (!nobus && we) begin
      if (be[0]) mdl[key][7:0] = wd[7:0];
      if (be[1]) mdl[key][15:8] = wd[15:8];
    end
  endtask

  initial begin
    int lat, scyc, bad;
    logic [1:0] sp;
    int r;

    repeat (3) @(negedge CLK);
    chk("rst_a", {15'd0, A}, 32'd0);
    chk("rst_do", {16'd0, DO}, 32'd0);
    chk("rst_bus", {26'd0, REG_CS_N, DRAM_CS_N, PAL_CS_N, RD_N, UWR_N, LWR_N}, 32'h3f);
    chk("rst_flags", {29'd0, BUSY, DONE, ERR}, 32'd0);
    chk("rst_rd", {16'd0, RD_DATA}, 32'd0);
    RST = 1'b0;

    run(2'd0, 17'h00005, 1'b1, 2'b11, 16'h0001, 0, "reg_wr");
    chk("reg_wr_pat", {26'd0, strb_pat}, 32'b011100);
    chk("reg_wr_fs", {16'd0, smem[{2'd0, 17'h00005}]}, 32'h1);
    chk("reg_wr_busy", {31'd0, BUSY}, 32'd0);
    @(posedge CLK); #1;
    chk("done_pulse", {31'd0, DONE}, 32'd0);

    run(2'd0, 17'h00002, 1'b1, 2'b11, 16'h0080, 0, "reg2_wr");
    run(2'd0, 17'h00002, 1'b0, 2'b11, 16'h0000, 0, "reg2_rd");
    chk("reg2_rd_val", {16'd0, RD_DATA}, 32'h0080);
    chk("reg2_rd_pat", {26'd0, strb_pat}, 32'b011011);

    run(2'd1, 17'h10010, 1'b1, 2'b01, 16'h00AB, 0, "dram_bw");
    chk("dram_bw_pat", {26'd0, strb_pat}, 32'b101110);
    run(2'd1, 17'h10010, 1'b0, 2'b11, 16'h0000, 1, "dram_rd");
    chk("dram_rd_val", {16'd0, RD_DATA}, 32'h00AB);

    run(2'd1, 17'h10020, 1'b1, 2'b11, 16'h1234, 200, "fill");

    run(2'd2, 17'h00003, 1'b1, 2'b10, 16'h1111, 0, "pal_bw");
    run(2'd2, 17'h00003, 1'b1, 2'b11, 16'h7FFF, 0, "pal_wr");
    chk("pal_wr_pat", {26'd0, strb_pat}, 32'b110100);
    run(2'd2, 17'h00003, 1'b0, 2'b11, 16'h0000, 0, "pal_rd");
    chk("pal_rd_val", {16'd0, RD_DATA}, 32'h7FFF);
    run(2'd3, 17'h00001, 1'b0, 2'b11, 16'h0000, 0, "resv");

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      sp = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      run(sp, 17'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
          16'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    chk("no_strobe_glitch", glitches, 0);

    stub_never = 1'b1;
`ifdef S32X_VDPM_TIMEOUT_EN
    access(2'd0, 17'h00004, 1'b0, 2'b11, 16'h0000, lat, scyc);
    chk("tmo_lat", lat, 1026);
    chk("tmo_err", {31'd0, ERR}, 32'd1);
    chk("tmo_rd", {16'd0, RD_DATA}, 32'hFFFF);
`endif
    @(negedge CLK);
    REQ = 1'b1; REQ_SPACE = 2'd0; REQ_A = 17'h00004; REQ_WE = 1'b0; REQ_BE = 2'b11;
    @(negedge CLK);
    REQ = 1'b0;
`ifdef S32X_VDPM_TIMEOUT_EN
    repeat (20) @(negedge CLK);
`else
    bad = 0;
    repeat (5000) begin
      @(negedge CLK);
      if (BUSY !== 1'b1 || DONE !== 1'b0) bad++;
    end
    chk("noack_busy", bad, 0);
`endif
    chk("stuck_strobe", {31'd0, strb_low}, 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_mid_bus", {26'd0, REG_CS_N, DRAM_CS_N, PAL_CS_N, RD_N, UWR_N, LWR_N}, 32'h3f);
    chk("rst_mid_flags", {29'd0, BUSY, DONE, ERR}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    stub_never = 1'b0;
    run(2'd0, 17'h00002, 1'b0, 2'b11, 16'h0000, 0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
